bit_serializer: RTL and testbench
=================================

# bit_serializer

Upstream stage of the serial multiple-of-3 detector: captures a parallel WIDTH-bit word and shifts it out MSB-first, one bit per slow bit period, with a per-bit sample strobe. It also emits a frame-start pulse so the detector can be cleared before each word. It replaces the detector's free-running slow clock with an enable-style `bit_tick` strobe in the `clock` domain.

## Interface
- `WIDTH`, 8, word length in bits; minimum 1.
- `TICK_DIV`, 20000000, `clock` cycles per serial bit; minimum 1.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high; clock `clock`.
- `start`  in  1  level input; a rising edge requests one frame.
- `data_in`  in  WIDTH  word; sampled only on the accepted start edge.
- `busy`  out  1  high from capture until and including the `done` cycle.
- `frame_start`  out  1  one-cycle pulse; downstream clears its state.
- `bit_out`  out  1  current serial bit, MSB first.
- `bit_valid`  out  1  high while `bit_out` carries a frame bit.
- `bit_tick`  out  1  one-cycle strobe in the last cycle of each bit window; downstream samples `bit_out` here.
- `bit_count`  out  $clog2(WIDTH+1)  index of the bit currently on `bit_out`.
- `done`  out  1  one-cycle pulse after the last bit window.
- `expect_div3`  out  1  reference result (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- Start edge: `start & ~start_q`, where `start_q` is a registered copy of `start`. `start_q` resets to 1, so a `start` held high through reset does not trigger a frame.
- IDLE: on an edge, load the shift register with `data_in`, clear `bit_count` and the tick counter, assert `frame_start`, and go to SHIFT.
- SHIFT:
  - `bit_out` = shift register MSB; `bit_valid` = 1.
  - Tick counter increments each cycle. At TICK_DIV-1 it asserts `bit_tick` and wraps to 0.
  - On a tick, if `bit_count` == WIDTH-1, go to DONE. Otherwise shift left by 1 and increment `bit_count`.
- DONE: `done` = 1 and `bit_valid` = 0 for one cycle, then return to IDLE.
- Start edges outside IDLE are ignored and not queued.
- Reset mid-frame aborts immediately. No `done` is issued.
- All outputs reset to 0, state resets to IDLE, and the shift register, counters and `expect_div3` clear.
- Outputs are registered, except `bit_out`, which is a direct register bit.

## Timing
- Cycle 0 is the first cycle after the capturing edge.
- Cycle 0: `frame_start` = 1, `busy` = 1, `bit_valid` = 1, `bit_out` = `data_in[WIDTH-1]`.
- Bit i is held for cycles i·TICK_DIV … (i+1)·TICK_DIV−1. `bit_tick` fires in the final cycle of that window.
- `done` fires at cycle WIDTH·TICK_DIV. `busy` drops the following cycle.
- With TICK_DIV = 1, `bit_tick` is high every SHIFT cycle.
- The earliest next start edge is accepted 1 cycle after `done`.

## Configuration
- `SERIALIZER_EXPECT_EN` defined:
  - At capture, register `expect_div3` = (`data_in` mod 3 == 0), computed iteratively or combinationally from the same word.
  - The value is held until the next capture or reset.
- Undefined: `expect_div3` is tied to 0 and no modulo logic is built.

## Structure
- Package `bit_serializer_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - defaults `BS_WIDTH_DEF` = 8 and `BS_TICK_DIV_DEF` = 20000000;
  - a function `mod3_zero(word)`.
- Sub-module `tick_gen`: enable-gated, clearable divider producing `bit_tick` every TICK_DIV cycles while enabled. It is reusable by other slow-rate lab blocks.

## Test plan
Benches run with WIDTH = 4 and TICK_DIV = 3.
- `data_in` = 4'b1001, start edge:
  - `bit_out` = 1,0,0,1; ticks at cycles 2, 5, 8, 11;
  - `done` at cycle 12; `expect_div3` = 1 when enabled.
- `data_in` = 4'b0111: serial sequence 0,1,1,1; `expect_div3` = 0.
- Second start edge at cycle 4 of a frame: ignored; exactly 4 ticks and one `done`.
- Reset asserted at cycle 7: all outputs are 0 next cycle; no `done`; a new start after release runs a full frame.
- `start` held high through reset release: no frame. Drop, then raise: frame starts; `frame_start` is a single-cycle pulse.
- TICK_DIV = 1, `data_in` = 4'b1100: ticks on cycles 0–3; `done` at cycle 4.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared types, defaults and helpers for the bit serializer.
package bit_serializer_pkg;

   // Frame sequencing states.
   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } bs_state_e;

   localparam int unsigned BS_WIDTH_DEF    = 8;
   localparam int unsigned BS_TICK_DIV_DEF = 20000000;

   // True when the word is a multiple of three. Words narrower than 64 bits are
   // zero-extended by the caller; leading zeros do not change the remainder.
   function automatic logic mod3_zero(input logic [63:0] word);
      logic [1:0] rem;
      logic [2:0] acc;
      rem = 2'd0;
      for (int i = 63; i >= 0; i--) begin
         // Horner step: rem = (2*rem + bit) mod 3, with 2*rem + bit in 0..5.
         acc = {rem, 1'b0} + {2'b00, word[i]};
         rem = (acc >= 3'd3) ? 2'(acc - 3'd3) : acc[1:0];
      end
      return rem == 2'd0;
   endfunction

endpackage

// File: rtl/bit_serializer_tick_gen.sv
// Enable-gated, clearable divider emitting a one-cycle registered strobe every
// TICK_DIV enabled cycles. en_i/clr_i describe the cycle that follows the
// current edge, which keeps tick_o a plain register with no combinational tail.
module tick_gen #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick_q, tick_d;

   // Next count and strobe: clear restarts the window, enable advances it.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      end
      tick_d = en_i && (cnt_d == CntMax);
   end

   // Counter and strobe registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the multiple-of-3 detector: captures a word
// on a start edge and shifts it out MSB-first, one bit per TICK_DIV cycles.
// Optional feature macro: SERIALIZER_EXPECT_EN (registers a reference mod-3 result).
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH    = BS_WIDTH_DEF,
   parameter int unsigned TICK_DIV = BS_TICK_DIV_DEF,
   localparam int unsigned BcW     = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] data_in_i,
   output logic             busy_o,
   output logic             frame_start_o,
   output logic             bit_out_o,
   output logic             bit_valid_o,
   output logic             bit_tick_o,
   output logic [BcW-1:0]   bit_count_o,
   output logic             done_o,
   output logic             expect_div3_o
);

   localparam logic [BcW-1:0] LastBit = BcW'(WIDTH - 1);

   bs_state_e        state_q, state_d;
   logic             start_q;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BcW-1:0]   bcnt_q, bcnt_d;
   logic             busy_q, busy_d;
   logic             fstart_q, fstart_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             capture;
   logic             start_edge;
   logic             bit_tick;

   assign start_edge = start_i & ~start_q;

   // Next-state and registered-output decode for the frame FSM.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bcnt_d   = bcnt_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      fstart_d = 1'b0;
      done_d   = 1'b0;
      capture  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_edge) begin
               capture  = 1'b1;
               shreg_d  = data_in_i;
               bcnt_d   = '0;
               fstart_d = 1'b1;
               busy_d   = 1'b1;
               valid_d  = 1'b1;
               state_d  = StShift;
            end
         end
         StShift: begin
            if (bit_tick) begin
               if (bcnt_q == LastBit) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  shreg_d = shreg_q << 1;
                  bcnt_d  = bcnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; start_q resets high so a held start is not an edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         start_q  <= 1'b1;
         shreg_q  <= '0;
         bcnt_q   <= '0;
         busy_q   <= 1'b0;
         fstart_q <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_i;
         shreg_q  <= shreg_d;
         bcnt_q   <= bcnt_d;
         busy_q   <= busy_d;
         fstart_q <= fstart_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
      end
   end

   // Bit window timing; counts only in cycles that will be in StShift.
   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clock (clock),
      .reset (reset),
      .en_i  (state_d == StShift),
      .clr_i (capture),
      .tick_o(bit_tick)
   );

`ifdef SERIALIZER_EXPECT_EN
   logic expect_q;

   // Reference divisibility result, refreshed only on capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         expect_q <= 1'b0;
      end else if (capture) begin
         expect_q <= mod3_zero(64'(data_in_i));
      end
   end

   assign expect_div3_o = expect_q;
`else
   assign expect_div3_o = 1'b0;
`endif

   assign busy_o        = busy_q;
   assign frame_start_o = fstart_q;
   assign bit_out_o     = shreg_q[WIDTH-1];
   assign bit_valid_o   = valid_q;
   assign bit_tick_o    = bit_tick;
   assign bit_count_o   = bcnt_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: WIDTH=4 with TICK_DIV=3 (dut a) and TICK_DIV=1 (dut b).
module tb_bit_serializer;

`ifdef SERIALIZER_EXPECT_EN
   localparam bit ExpEn = 1'b1;
`else
   localparam bit ExpEn = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [3:0] data_a = '0, data_b = '0;

   logic       busy_a, fs_a, bo_a, bv_a, tick_a, done_a, exp_a;
   logic [2:0] bc_a;
   logic       busy_b, fs_b, bo_b, bv_b, tick_b, done_b, exp_b;
   logic [2:0] bc_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   bit_serializer #(.WIDTH(4), .TICK_DIV(3)) u_dut_a (
      .clock        (clock),
      .reset        (reset),
      .start_i      (start_a),
      .data_in_i    (data_a),
      .busy_o       (busy_a),
      .frame_start_o(fs_a),
      .bit_out_o    (bo_a),
      .bit_valid_o  (bv_a),
      .bit_tick_o   (tick_a),
      .bit_count_o  (bc_a),
      .done_o       (done_a),
      .expect_div3_o(exp_a)
   );

   bit_serializer #(.WIDTH(4), .TICK_DIV(1)) u_dut_b (
      .clock        (clock),
      .reset        (reset),
      .start_i      (start_b),
      .data_in_i    (data_b),
      .busy_o       (busy_b),
      .frame_start_o(fs_b),
      .bit_out_o    (bo_b),
      .bit_valid_o  (bv_b),
      .bit_tick_o   (tick_b),
      .bit_count_o  (bc_b),
      .done_o       (done_b),
      .expect_div3_o(exp_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, " busy"}, 32'(busy_a), 0);
      check({tag, " frame_start"}, 32'(fs_a), 0);
      check({tag, " bit_valid"}, 32'(bv_a), 0);
      check({tag, " bit_tick"}, 32'(tick_a), 0);
      check({tag, " done"}, 32'(done_a), 0);
   endtask

   // Runs one TICK_DIV=3 frame from a negedge; optional re-start edge and reset cycle.
   task automatic frame3(input logic [3:0] data, input bit div3, input int restart_at,
                         input int reset_at);
      bit aborted, act;
      start_a = 1'b1;
      data_a  = data;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         aborted = (reset_at >= 0) && (c > reset_at);
         act     = !aborted && (c < 12);
         check("frame_start", 32'(fs_a), 32'(!aborted && c == 0));
         check("busy", 32'(busy_a), 32'(!aborted && c <= 12));
         check("bit_valid", 32'(bv_a), 32'(act));
         check("bit_tick", 32'(tick_a), 32'(act && (c % 3 == 2)));
         check("done", 32'(done_a), 32'(!aborted && c == 12));
         if (act) begin
            check("bit_out", 32'(bo_a), 32'(data[3 - c / 3]));
            check("bit_count", 32'(bc_a), 32'(c / 3));
         end
         if (aborted) begin
            check("bit_out rst", 32'(bo_a), 0);
            check("bit_count rst", 32'(bc_a), 0);
            check("expect rst", 32'(exp_a), 0);
         end else if (c == 0 || c == 15) begin
            check("expect_div3", 32'(exp_a), 32'(ExpEn && div3));
         end
         // Word changes after capture must not leak into the frame.
         if (c == 0) begin
            start_a = 1'b0;
            data_a  = ~data;
         end
         if (c == restart_at) start_a = 1'b1;
         if (c == reset_at) reset = 1'b1;
      end
      start_a = 1'b0;
      reset   = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clock);
      check_idle_a("reset");
      check("reset bit_out", 32'(bo_a), 0);
      check("reset bit_count", 32'(bc_a), 0);
      check("reset expect", 32'(exp_a), 0);
      reset = 1'b0;
      @(negedge clock);

      // 9 and 7: basic serial order, tick spacing and reference result.
      frame3(4'b1001, 1'b1, -1, -1);
      frame3(4'b0111, 1'b0, -1, -1);
      // Second start edge at cycle 4 is ignored.
      frame3(4'b1010, 1'b0, 4, -1);
      // Reset at cycle 7 aborts with no done, then a full frame follows.
      frame3(4'b1001, 1'b1, -1, 7);
      frame3(4'b1100, 1'b1, -1, -1);

      // start held high through reset release must not start a frame.
      reset   = 1'b1;
      start_a = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check_idle_a("held start");
      end
      start_a = 1'b0;
      @(negedge clock);
      frame3(4'b0110, 1'b1, -1, -1);

      // TICK_DIV = 1: a tick every shift cycle.
      start_b = 1'b1;
      data_b  = 4'b1100;
      for (int c = 0; c < 7; c++) begin
         @(negedge clock);
         start_b = 1'b0;
         check("b frame_start", 32'(fs_b), 32'(c == 0));
         check("b bit_tick", 32'(tick_b), 32'(c < 4));
         check("b done", 32'(done_b), 32'(c == 4));
         check("b busy", 32'(busy_b), 32'(c <= 4));
         check("b bit_valid", 32'(bv_b), 32'(c < 4));
         if (c < 4) begin
            check("b bit_out", 32'(bo_b), 32'(data_b[3 - c]));
            check("b bit_count", 32'(bc_b), 32'(c));
         end
         if (c == 0) check("b expect_div3", 32'(exp_b), 32'(ExpEn));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
